// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encoding and fixed instruction codes.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_BYPASS = '1;

endpackage

// File: rtl/jtag_tap_fsm.sv
// Combinational half of the TAP controller: next-state table and state-decode flags.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  tap_state_e i_state,
    input  logic       i_tms,
    output tap_state_e o_next_state,
    output logic       o_in_tlr,
    output logic       o_in_capture_ir,
    output logic       o_in_shift_ir,
    output logic       o_in_update_ir,
    output logic       o_in_capture_dr,
    output logic       o_in_shift_dr,
    output logic       o_in_update_dr
);

    always_comb begin
        // NOTE: assign a default first so every path drives o_next_state and no latch is inferred.
        o_next_state = TEST_LOGIC_RESET;
        case (i_state)
            TEST_LOGIC_RESET: o_next_state = i_tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    o_next_state = i_tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        o_next_state = i_tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       o_next_state = i_tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:         o_next_state = i_tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:         o_next_state = i_tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         o_next_state = i_tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:         o_next_state = i_tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        o_next_state = i_tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        o_next_state = i_tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       o_next_state = i_tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:         o_next_state = i_tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:         o_next_state = i_tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         o_next_state = i_tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:         o_next_state = i_tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        o_next_state = i_tms ? SELECT_DR : RUN_TEST_IDLE;
            default:          o_next_state = TEST_LOGIC_RESET;
        endcase
    end

    assign o_in_tlr        = (i_state == TEST_LOGIC_RESET);
    assign o_in_capture_ir = (i_state == CAPTURE_IR);
    assign o_in_shift_ir   = (i_state == SHIFT_IR);
    assign o_in_update_ir  = (i_state == UPDATE_IR);
    assign o_in_capture_dr = (i_state == CAPTURE_DR);
    assign o_in_shift_dr   = (i_state == SHIFT_DR);
    assign o_in_update_dr  = (i_state == UPDATE_DR);

endmodule

// File: rtl/jtag_tap_target.sv
// JTAG TAP target with pins oversampled in the system clock domain; IDCODE, BYPASS and USER DRs.
module jtag_tap_target
    import jtag_tap_pkg::*;
#(
    parameter int                  IR_WIDTH   = 5,
    parameter int                  DR_WIDTH   = 32,
    parameter logic [31:0]         IDCODE_VAL = 32'h20000913,
    parameter logic [IR_WIDTH-1:0] USER_IR    = IR_WIDTH'(5'h10)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jtag_TCK,
    input  logic                jtag_TMS,
    input  logic                jtag_TDI,
    input  logic                jtag_TRSTn,
    output logic                jtag_TDO_data,
    output logic                jtag_TDO_driven,
    input  logic [DR_WIDTH-1:0] user_capture_data,
    output logic [DR_WIDTH-1:0] user_update_data,
    output logic                user_update_valid,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_value
);

    localparam logic [IR_WIDTH-1:0] LP_IR_IDCODE = IR_WIDTH'(IR_IDCODE);

    logic r_tck_meta, r_tck_sync, r_tck_hist;
    logic r_tms_meta, r_tms_sync;
    logic r_tdi_meta, r_tdi_sync;
    logic r_trstn_meta, r_trstn_sync;

    tap_state_e          r_state;
    logic [IR_WIDTH-1:0] r_ir_value, r_ir_shift;
    logic [31:0]         r_idcode_shift;
    logic                r_bypass_shift;
    logic [DR_WIDTH-1:0] r_user_shift, r_update_data;
    logic                r_update_valid, r_tdo_data, r_tdo_driven;

    tap_state_e w_next_state;
    logic w_in_tlr, w_in_capture_ir, w_in_shift_ir, w_in_update_ir;
    logic w_in_capture_dr, w_in_shift_dr, w_in_update_dr;
    logic w_tck_rise, w_tck_fall, w_sel_idcode, w_sel_user, w_dr_lsb;

    // TRSTn synchroniser idles high so leaving reset does not look like a TAP reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            {r_tck_meta, r_tck_sync, r_tck_hist} <= '0;
            {r_tms_meta, r_tms_sync, r_tdi_meta, r_tdi_sync} <= '0;
            {r_trstn_meta, r_trstn_sync} <= 2'b11;
        end else begin
            // NOTE: non-blocking so each flop samples its neighbour's pre-edge value.
            r_tck_meta   <= jtag_TCK;
            r_tck_sync   <= r_tck_meta;
            r_tck_hist   <= r_tck_sync;
            r_tms_meta   <= jtag_TMS;
            r_tms_sync   <= r_tms_meta;
            r_tdi_meta   <= jtag_TDI;
            r_tdi_sync   <= r_tdi_meta;
            r_trstn_meta <= jtag_TRSTn;
            r_trstn_sync <= r_trstn_meta;
        end
    end

    assign w_tck_rise   =  r_tck_sync & ~r_tck_hist;
    assign w_tck_fall   = ~r_tck_sync &  r_tck_hist;
    assign w_sel_idcode = (r_ir_value == LP_IR_IDCODE);
    assign w_sel_user   = !w_sel_idcode && (r_ir_value == USER_IR);
    assign w_dr_lsb     = w_sel_idcode ? r_idcode_shift[0] :
                          w_sel_user   ? r_user_shift[0]   : r_bypass_shift;

    jtag_tap_fsm u_fsm (
        .i_state         (r_state),
        .i_tms           (r_tms_sync),
        .o_next_state    (w_next_state),
        .o_in_tlr        (w_in_tlr),
        .o_in_capture_ir (w_in_capture_ir),
        .o_in_shift_ir   (w_in_shift_ir),
        .o_in_update_ir  (w_in_update_ir),
        .o_in_capture_dr (w_in_capture_dr),
        .o_in_shift_dr   (w_in_shift_dr),
        .o_in_update_dr  (w_in_update_dr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= TEST_LOGIC_RESET;
            r_ir_value     <= LP_IR_IDCODE;
            r_ir_shift     <= '0;
            r_idcode_shift <= '0;
            r_bypass_shift <= 1'b0;
            r_user_shift   <= '0;
            r_update_data  <= '0;
            r_update_valid <= 1'b0;
            r_tdo_data     <= 1'b0;
            r_tdo_driven   <= 1'b0;
        end else begin
            r_update_valid <= 1'b0;
            if (!r_trstn_sync) begin
                // TAP reset wins over any TCK edge seen in the same clock.
                r_state      <= TEST_LOGIC_RESET;
                r_ir_value   <= LP_IR_IDCODE;
                r_tdo_data   <= 1'b0;
                r_tdo_driven <= 1'b0;
            end else begin
                if (w_in_tlr)
                    r_ir_value <= LP_IR_IDCODE;
                if (w_tck_rise) begin
                    if (w_in_capture_ir)
                        r_ir_shift <= IR_WIDTH'(2'b01);
                    if (w_in_shift_ir)
                        r_ir_shift <= {r_tdi_sync, r_ir_shift[IR_WIDTH-1:1]};
                    if (w_in_capture_dr) begin
                        if (w_sel_idcode)    r_idcode_shift <= IDCODE_VAL;
                        else if (w_sel_user) r_user_shift   <= user_capture_data;
                        else                 r_bypass_shift <= 1'b0;
                    end
                    if (w_in_shift_dr) begin
                        if (w_sel_idcode)
                            r_idcode_shift <= {r_tdi_sync, r_idcode_shift[31:1]};
                        else if (w_sel_user)
                            r_user_shift <= (r_user_shift >> 1) |
                                            (DR_WIDTH'(r_tdi_sync) << (DR_WIDTH - 1));
                        else
                            r_bypass_shift <= r_tdi_sync;
                    end
                    r_state <= w_next_state;
                end
                if (w_tck_fall) begin
                    if (w_in_update_ir)
                        r_ir_value <= r_ir_shift;
                    if (w_in_update_dr && w_sel_user) begin
                        r_update_data  <= r_user_shift;
                        r_update_valid <= 1'b1;
                    end
                    r_tdo_data   <= w_in_shift_ir ? r_ir_shift[0] :
                                    w_in_shift_dr ? w_dr_lsb      : 1'b0;
                    r_tdo_driven <= w_in_shift_ir || w_in_shift_dr;
                end
            end
        end
    end

    assign jtag_TDO_data     = r_tdo_data;
    assign jtag_TDO_driven   = r_tdo_driven;
    assign user_update_data  = r_update_data;
    assign user_update_valid = r_update_valid;
    assign tap_state         = r_state;
    assign ir_value          = r_ir_value;

endmodule
